// File: rtl/multicycle_control_pkg.sv
// Shared constants, state encoding and control-word layout for the multicycle MIPS control path.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXE   = 4'd7,
    RWB    = 4'd8,
    BEQ    = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JMP    = 4'd12
  } state_t;

  // Registered Moore control word; the *_rdy/*_zero enables still need their qualifier applied.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_rdy;
    logic       pc_write_zero;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the IR/ALU flags, the memory handshake and the datapath enables.
interface multicycle_control_if;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic       illegal;
  logic       mem_err;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, illegal, mem_err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, illegal, mem_err
  );

endinterface

// File: rtl/multicycle_control_wait_timer.sv
// Counts stalled cycles in a memory state and flags the last cycle allowed before an abort.
module multicycle_control_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT - 1));

  // Clearing on expiry and whenever the wait ends means every memory-state entry starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (!wait_en || expired)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core with a bounded memory-ready wait.
// Jump support is built only when MC_JUMP_EN is defined; otherwise opcode 000010 is illegal.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_if.master        bus
);

  state_t state;
  state_t nxt;
  ctrl_t  ctl;
  logic   expired;
  logic   wait_en;
  logic   timeout;
  logic   op_legal;

  assign wait_en = ctl.mem_req & ~bus.mem_ready;
  assign timeout = wait_en & expired;

  multicycle_control_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .wait_en (wait_en),
    .expired (expired)
  );

  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req      = 1'b1;
        c.ir_write     = 1'b1;
        c.pc_write_rdy = 1'b1;
        c.alu_src_b    = SRCB_FOUR;
        c.alu_op       = ALUOP_ADD;
        c.pc_src       = PCSRC_ALU;
      end
      DECODE: c.alu_src_b = SRCB_IMM_SH;
      MEMADR, ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWR: begin
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      REXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_src        = PCSRC_ALUOUT;
        c.pc_write_zero = 1'b1;
      end
      ADDIWB: c.reg_write = 1'b1;
`ifdef MC_JUMP_EN
      JMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: op_legal = 1'b1;
`ifdef MC_JUMP_EN
      OP_J: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // A timed-out access falls back to FETCH; FETCH simply re-enters itself with a fresh count.
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:   nxt = FETCH;
      FETCH:  nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = REXE;
          OP_BEQ:       nxt = BEQ;
          OP_ADDI:      nxt = ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         nxt = JMP;
`endif
          default:      nxt = FETCH;
        endcase
      end
      MEMADR: nxt = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = bus.mem_ready ? MEMWB : (timeout ? FETCH : MEMRD);
      MEMWR:  nxt = (bus.mem_ready || timeout) ? FETCH : MEMWR;
      MEMWB:  nxt = FETCH;
      REXE:   nxt = RWB;
      RWB:    nxt = FETCH;
      BEQ:    nxt = FETCH;
      ADDIEX: nxt = ADDIWB;
      ADDIWB: nxt = FETCH;
`ifdef MC_JUMP_EN
      JMP:    nxt = FETCH;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= decode_ctrl(nxt);
    end
  end

  assign bus.mem_req  = ctl.mem_req & ~timeout;
  assign bus.MemWrite = ctl.mem_write & bus.mem_ready;
  assign bus.IorD     = ctl.iord;
  assign bus.IRWrite  = ctl.ir_write & bus.mem_ready;
  assign bus.RegWrite = ctl.reg_write;
  assign bus.RegDst   = ctl.reg_dst;
  assign bus.MemtoReg = ctl.mem_to_reg;
  assign bus.ALUSrcA  = ctl.alu_src_a;
  assign bus.ALUSrcB  = ctl.alu_src_b;
  assign bus.ALUOp    = ctl.alu_op;
  assign bus.PCSrc    = ctl.pc_src;
  assign bus.PCWrite  = ctl.pc_write
                      | (ctl.pc_write_rdy & bus.mem_ready)
                      | (ctl.pc_write_zero & bus.zero);
  assign bus.illegal  = (state == DECODE) & ~op_legal;
  assign bus.mem_err  = timeout;

endmodule
